// File: rtl/ctrl_mem_slices_if.sv
// Control/status bundle between the slice sequencer and its host.
// The slave side is the sequencer; the master side issues passes and watches slice traffic.
interface ctrl_mem_slices_if #(
  parameter int STG_W = 4,
  parameter int SLC_W = 2
);
  logic             start;
  logic             mode;
  logic             stall;
  logic             busy;
  logic             done;
  logic [STG_W-1:0] rd_stage;
  logic [STG_W-1:0] wr_stage;
  logic             wren_MEMS;
  logic [SLC_W-1:0] wrslc_MEMS;
  logic [SLC_W-1:0] rdslc_MEMS;
  logic             slcwraddr_MEMS;

  modport master (
    output start, mode, stall,
    input  busy, done, rd_stage, wr_stage, wren_MEMS, wrslc_MEMS, rdslc_MEMS, slcwraddr_MEMS
  );

  modport slave (
    input  start, mode, stall,
    output busy, done, rd_stage, wr_stage, wren_MEMS, wrslc_MEMS, rdslc_MEMS, slcwraddr_MEMS
  );
endinterface

// File: rtl/ctrl_mem_slices.sv
// Pass sequencer for a ring of memory slices: walks read/write stages, pulses slice
// writes from per-mode stage masks, and rotates read/write slice pointers around the ring.

module ctrl_mem_slices_ptr #(
  parameter int NSLC  = 4,
  parameter int SLC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [SLC_W-1:0] ptr_q
);
  logic [SLC_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv) ptr_d = (ptr_q == SLC_W'(NSLC - 1)) ? '0 : ptr_q + SLC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

module ctrl_mem_slices #(
  parameter int              NSLC   = 4,
  parameter int              SLC_W  = 2,
  parameter int              STG_W  = 4,
  parameter int              NSTG   = 12,
  parameter int              WLAT   = 3,
  parameter logic [NSTG-1:0] WMASK0 = 12'h248,
  parameter logic [NSTG-1:0] WMASK1 = 12'h920,
  parameter logic [NSTG-1:0] RMASK0 = 12'h092,
  parameter logic [NSTG-1:0] RMASK1 = 12'h0A4
) (
  input logic             clk,
  input logic             rst,
  ctrl_mem_slices_if.slave io
);
  localparam int CNT_W = STG_W + 1;
  localparam int MW    = 1 << STG_W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             wren_q, wren_d;
  logic             wraddr_q, wraddr_d;
  logic             rd_adv;

  logic             rd_valid, wr_valid, last_adv;
  logic [STG_W-1:0] rd_stage, wr_stage;
  logic [MW-1:0]    wmask, rmask;

  // Stage counter runs WLAT advances past the last read stage so the write side can drain.
  assign rd_valid = cnt_q < CNT_W'(NSTG);
  assign wr_valid = cnt_q >= CNT_W'(WLAT);
  assign last_adv = cnt_q == CNT_W'(NSTG - 1 + WLAT);
  assign rd_stage = rd_valid ? STG_W'(cnt_q) : STG_W'(NSTG - 1);
  assign wr_stage = wr_valid ? STG_W'(cnt_q - CNT_W'(WLAT)) : '0;

  // Masks are widened to the full stage-index range so any index is in bounds.
  assign wmask = MW'(mode_q ? WMASK1 : WMASK0);
  assign rmask = MW'(mode_q ? RMASK1 : RMASK0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    wren_d   = 1'b0;
    wraddr_d = wraddr_q;
    rd_adv   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d = RUN;
          cnt_d   = '0;
          mode_d  = io.mode;
        end
      end
      RUN: begin
        if (!io.stall) begin
          wren_d = wr_valid & wmask[wr_stage];
          rd_adv = rd_valid & rmask[rd_stage];
          if (last_adv) begin
            state_d  = IDLE;
            cnt_d    = '0;
            done_d   = 1'b1;
            wraddr_d = ~wraddr_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      wren_q   <= 1'b0;
      wraddr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
    end
  end

  // Pointer 0 follows issued write pulses, pointer 1 follows qualifying read stages.
  logic [1:0]            ptr_adv;
  logic [1:0][SLC_W-1:0] ptr;

  assign ptr_adv = {rd_adv, wren_q};

  for (genvar g = 0; g < 2; g++) begin : g_ptr
    ctrl_mem_slices_ptr #(.NSLC(NSLC), .SLC_W(SLC_W)) u_ptr (
      .clk   (clk),
      .rst   (rst),
      .adv   (ptr_adv[g]),
      .ptr_q (ptr[g])
    );
  end

  assign io.busy           = (state_q == RUN);
  assign io.done           = done_q;
  assign io.rd_stage       = rd_stage;
  assign io.wr_stage       = wr_stage;
  assign io.wren_MEMS      = wren_q;
  assign io.wrslc_MEMS     = ptr[0];
  assign io.rdslc_MEMS     = ptr[1];
  assign io.slcwraddr_MEMS = wraddr_q;
endmodule
